morse_timer_bank: RTL and testbench

MORSE_TIMER_BANK -- requirements
Module: morse_timer_bank

---
 rtl/morse_timer_bank.sv | 98 +++++++++
 tb/tb_morse_timer_bank.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/morse_timer_bank.sv
// rtl/morse_timer_bank.sv - four independent ms timeout channels (button, dash, inter-character, word)
// Each channel counts LIMIT*TICK_DIV cycles from its last restart, then holds a sticky timeout.
module morse_timer_bank #(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned BTN_MS   = 2000,
    parameter int unsigned DASH_MS  = 300,
    parameter int unsigned INTER_MS = 600,
    parameter int unsigned WORD_MS  = 1400
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       btn_to_res,
    input  logic       dash_to_res,
    input  logic       inter_to_res,
    input  logic       word_to_res,
    output logic       btn_to,
    output logic       dash_to,
    output logic       inter_to,
    output logic       word_to,
    output logic [3:0] busy
);

    localparam int SW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [3:0] res;
    logic [3:0] to_vec;
    logic [3:0] busy_vec;

    assign res = {word_to_res, inter_to_res, dash_to_res, btn_to_res};

    for (genvar g = 0; g < 4; g++) begin : g_chan
        localparam int unsigned LIM = (g == 0) ? BTN_MS  :
                                      (g == 1) ? DASH_MS :
                                      (g == 2) ? INTER_MS : WORD_MS;
        localparam int MSW = (LIM > 1) ? $clog2(LIM) : 1;
        localparam logic [SW-1:0]  SUB_MAX = SW'(TICK_DIV - 1);
        localparam logic [MSW-1:0] MS_MAX  = MSW'(LIM - 1);

        state_t         state_q;
        logic [SW-1:0]  sub_q;
        logic [MSW-1:0] ms_q;
        logic           to_q;
        logic           busy_q;

        always_ff @(posedge clk_100MHz) begin
            if (reset) begin
                state_q <= IDLE;
                sub_q   <= '0;
                ms_q    <= '0;
                to_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else if (res[g]) begin
                // A restart beats an expiry landing in the same cycle.
                state_q <= RUN;
                sub_q   <= '0;
                ms_q    <= '0;
                to_q    <= 1'b0;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    RUN: begin
                        if (sub_q == SUB_MAX) begin
                            sub_q <= '0;
                            if (ms_q == MS_MAX) begin
                                state_q <= DONE;
                                to_q    <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                ms_q <= ms_q + 1'b1;
                            end
                        end else begin
                            sub_q <= sub_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end

        assign to_vec[g]   = to_q;
        assign busy_vec[g] = busy_q;
    end

    assign btn_to   = to_vec[0];
    assign dash_to  = to_vec[1];
    assign inter_to = to_vec[2];
    assign word_to  = to_vec[3];
    assign busy     = busy_vec;

endmodule

// File: tb/tb_morse_timer_bank.sv
// tb/tb_morse_timer_bank.sv - bench for morse_timer_bank with two parameter sets
module tb_morse_timer_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] res;

    logic       a_btn, a_dash, a_inter, a_word;
    logic [3:0] a_busy;
    logic       b_btn, b_dash, b_inter, b_word;
    logic [3:0] b_busy;
    logic [3:0] a_to, b_to;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    morse_timer_bank #(.TICK_DIV(4), .BTN_MS(2), .DASH_MS(3), .INTER_MS(2), .WORD_MS(1)) u_a (
        .clk_100MHz(clk), .reset(rst),
        .btn_to_res(res[0]), .dash_to_res(res[1]), .inter_to_res(res[2]), .word_to_res(res[3]),
        .btn_to(a_btn), .dash_to(a_dash), .inter_to(a_inter), .word_to(a_word), .busy(a_busy)
    );

    morse_timer_bank #(.TICK_DIV(4), .BTN_MS(1), .DASH_MS(2), .INTER_MS(3), .WORD_MS(4)) u_b (
        .clk_100MHz(clk), .reset(rst),
        .btn_to_res(res[0]), .dash_to_res(res[1]), .inter_to_res(res[2]), .word_to_res(res[3]),
        .btn_to(b_btn), .dash_to(b_dash), .inter_to(b_inter), .word_to(b_word), .busy(b_busy)
    );

    assign a_to = {a_word, a_inter, a_dash, a_btn};
    assign b_to = {b_word, b_inter, b_dash, b_btn};

    // Reference: a channel expires once LIMIT*TICK_DIV edges have passed since its last restart.
    int edge_no = 0;
    int last_res[8];
    bit armed[8];
    int lim[8] = '{2, 3, 2, 1, 1, 2, 3, 4};

    always @(posedge clk) begin
        edge_no = edge_no + 1;
        for (int i = 0; i < 8; i++) begin
            if (rst) armed[i] = 1'b0;
            else if (res[i % 4]) begin
                armed[i]    = 1'b1;
                last_res[i] = edge_no;
            end
        end
    end

    function automatic logic [3:0] m_to(input int base);
        logic [3:0] v;
        for (int i = 0; i < 4; i++)
            v[i] = armed[base+i] && ((edge_no - last_res[base+i]) >= lim[base+i] * 4);
        return v;
    endfunction

    function automatic logic [3:0] m_busy(input int base);
        logic [3:0] v;
        for (int i = 0; i < 4; i++)
            v[i] = armed[base+i] && ((edge_no - last_res[base+i]) < lim[base+i] * 4);
        return v;
    endfunction

    task automatic cyc(input logic r, input logic [3:0] v);
        rst = r;
        res = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        cyc(1'b1, 4'hF);
        checks++;
        if ({a_to, a_busy, b_to, b_busy} !== 16'h0) begin
            errors++;
            $display("FAIL reset_priority got=%b exp=0", {a_to, a_busy, b_to, b_busy});
        end
        for (int n = 0; n < 5; n++) begin
            cyc(1'b1, 4'h0);
            checks++;
            if ({a_to, a_busy, b_to, b_busy} !== 16'h0) begin
                errors++;
                $display("FAIL reset_hold n=%0d got=%b exp=0", n, {a_to, a_busy, b_to, b_busy});
            end
        end
    endtask

    task automatic test_dash_timeout;
        cyc(1'b1, 4'h0);
        for (int n = 0; n <= 72; n++) begin
            cyc(1'b0, (n == 10) ? 4'b0010 : 4'b0000);
            checks++;
            if (a_dash !== (n >= 22)) begin
                errors++;
                $display("FAIL dash_to n=%0d got=%b exp=%b", n, a_dash, (n >= 22));
            end
            if (n >= 11) begin
                checks++;
                if (a_busy[1] !== (n <= 21)) begin
                    errors++;
                    $display("FAIL dash_busy n=%0d got=%b exp=%b", n, a_busy[1], (n <= 21));
                end
            end
        end
    endtask

    task automatic test_restart;
        cyc(1'b1, 4'h0);
        for (int n = 0; n <= 20; n++) begin
            cyc(1'b0, (n == 0 || n == 6) ? 4'b0100 : 4'b0000);
            checks++;
            if (a_inter !== (n >= 14)) begin
                errors++;
                $display("FAIL inter_restart n=%0d got=%b exp=%b", n, a_inter, (n >= 14));
            end
        end
    endtask

    task automatic test_expiry_race;
        cyc(1'b1, 4'h0);
        for (int n = 0; n <= 24; n++) begin
            cyc(1'b0, (n == 0 || n == 8) ? 4'b0001 : 4'b0000);
            checks++;
            if (a_btn !== (n >= 16)) begin
                errors++;
                $display("FAIL btn_race n=%0d got=%b exp=%b", n, a_btn, (n >= 16));
            end
        end
    endtask

    task automatic test_simultaneous;
        logic [3:0] exp;
        cyc(1'b1, 4'h0);
        for (int n = 0; n <= 20; n++) begin
            cyc(1'b0, (n == 0) ? 4'hF : 4'h0);
            for (int i = 0; i < 4; i++) exp[i] = (n >= 4 * (i + 1));
            checks++;
            if (b_to !== exp) begin
                errors++;
                $display("FAIL simultaneous n=%0d got=%b exp=%b", n, b_to, exp);
            end
        end
    endtask

    task automatic test_reset_midcount;
        cyc(1'b1, 4'h0);
        for (int n = 0; n <= 80; n++) begin
            cyc((n == 5), (n == 0 || n == 61) ? 4'b1000 : 4'b0000);
            checks++;
            if (n < 5 || n >= 61) begin
                if ({b_word, b_busy[3]} !== {(n >= 77), (n < 77)}) begin
                    errors++;
                    $display("FAIL word_run n=%0d got=%b exp=%b", n, {b_word, b_busy[3]}, {(n >= 77), (n < 77)});
                end
            end else if ({b_word, b_busy} !== 5'b0) begin
                errors++;
                $display("FAIL word_after_reset n=%0d got=%b exp=0", n, {b_word, b_busy});
            end
        end
    endtask

    task automatic test_held_res;
        cyc(1'b1, 4'h0);
        for (int n = 0; n <= 20; n++) begin
            cyc(1'b0, (n <= 9) ? 4'b1000 : 4'b0000);
            checks++;
            if (a_word !== (n >= 13)) begin
                errors++;
                $display("FAIL word_held n=%0d got=%b exp=%b", n, a_word, (n >= 13));
            end
        end
    endtask

    task automatic test_random;
        logic [3:0] v;
        logic [15:0] exp;
        cyc(1'b1, 4'h0);
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++) v[i] = ($urandom_range(0, 11) == 0);
            cyc(($urandom_range(0, 99) == 0), v);
            exp = {m_to(0), m_busy(0), m_to(4), m_busy(4)};
            checks++;
            if ({a_to, a_busy, b_to, b_busy} !== exp) begin
                errors++;
                $display("FAIL random n=%0d got=%b exp=%b", n, {a_to, a_busy, b_to, b_busy}, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        res = 4'h0;
        @(negedge clk);
        test_reset;
        test_dash_timeout;
        test_restart;
        test_expiry_race;
        test_simultaneous;
        test_reset_midcount;
        test_held_res;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
